// File: rtl/axis_buf_pkg.sv
// ============================================================================
// Module      : axis_buf_pkg
// Description : Shared occupancy encodings and width helper for the AXI-Stream
//               register buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_buf_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_PARTIAL = 2'b01,
    OCC_FULL    = 2'b10
  } occ_state_t;

  // Bits needed to represent values 0..n-1, never less than one.
  function automatic int calc_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_buf_mem.sv
// ============================================================================
// Module      : axis_buf_mem
// Description : DEPTH x (DATA_W+1) register array, synchronous write and reset,
//               asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_buf_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W:0]   wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W:0]   rdata_o
);

  logic [DATA_W:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

`default_nettype wire

// File: rtl/axis_reg_fifo.sv
// ============================================================================
// Module      : axis_reg_fifo
// Description : AXI-Stream register FIFO carrying tlast, with synchronous flush
//               and registered occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_reg_fifo
  import axis_buf_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = calc_width(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              tvalid_i,
  output logic              tready_o,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              tlast_i,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tlast_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = calc_width(DEPTH);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one_cnt  = CNT_W'(1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  occ_state_t       r_state;
  occ_state_t       w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic [DATA_W:0]  w_rd_entry;

  // Handshakes depend only on registered occupancy and flush.
  assign tready_o = (r_state != OCC_FULL)  && !flush_i;
  assign tvalid_o = (r_state != OCC_EMPTY) && !flush_i;
  assign w_push   = tvalid_i && tready_o;
  assign w_pop    = tvalid_o && tready_i;

  axis_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr),
    .wdata_i ({tlast_i, tdata_i}),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rd_entry)
  );

  assign tlast_o = w_rd_entry[DATA_W];
  assign tdata_o = w_rd_entry[DATA_W-1:0];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_one_cnt;
      else if (w_pop && !w_push) r_count <= r_count - c_one_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) r_state <= OCC_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY:   if (w_push) w_state_nxt = OCC_PARTIAL;
        OCC_PARTIAL: begin
          if (w_pop && !w_push && r_count == c_one_cnt)
            w_state_nxt = OCC_EMPTY;
          else if (w_push && !w_pop && r_count == c_full_cnt - c_one_cnt)
            w_state_nxt = OCC_FULL;
        end
        OCC_FULL:    if (w_pop) w_state_nxt = OCC_PARTIAL;
        default:     w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_reg_fifo.sv
// ============================================================================
// Module      : tb_axis_reg_fifo
// Description : Directed self-checking bench for axis_reg_fifo (DATA_W=8, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_reg_fifo;

  logic       clk_i = 1'b0;
  logic       arstn_i;
  logic       tvalid_i;
  logic       tready_o;
  logic [7:0] tdata_i;
  logic       tlast_i;
  logic       tvalid_o;
  logic       tready_i;
  logic [7:0] tdata_o;
  logic       tlast_o;
  logic       flush_i;
  logic [2:0] count_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  axis_reg_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .tvalid_i (tvalid_i),
    .tready_o (tready_o),
    .tdata_i  (tdata_i),
    .tlast_i  (tlast_i),
    .tvalid_o (tvalid_o),
    .tready_i (tready_i),
    .tdata_o  (tdata_o),
    .tlast_o  (tlast_o),
    .flush_i  (flush_i),
    .count_o  (count_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    arstn_i = 1'b0; tvalid_i = 1'b0; tready_i = 1'b0; flush_i = 1'b0;
    tdata_i = 8'h00; tlast_i = 1'b0;
    step(); step();
    arstn_i = 1'b1;
    #1;
    n_cmp++; if (tready_o !== 1'b1) begin n_err++; $display("FAIL reset_tready got=%b exp=1", tready_o); end
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", tvalid_o); end
    n_cmp++; if (tdata_o !== 8'h00) begin n_err++; $display("FAIL reset_tdata got=%h exp=00", tdata_o); end
    n_cmp++; if (tlast_o !== 1'b0) begin n_err++; $display("FAIL reset_tlast got=%b exp=0", tlast_o); end
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    tready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      tvalid_i = 1'b1; tdata_i = d;
      step();
      n_cmp++; if (count_o !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count beat=%0d got=%0d exp=%0d", i, count_o, i + 1); end
    end
    n_cmp++; if (tready_o !== 1'b0) begin n_err++; $display("FAIL fill_tready_full got=%b exp=0", tready_o); end
    n_cmp++; if (tvalid_o !== 1'b1) begin n_err++; $display("FAIL fill_tvalid got=%b exp=1", tvalid_o); end
    n_cmp++; if (tdata_o !== 8'h11) begin n_err++; $display("FAIL fill_head got=%h exp=11", tdata_o); end
    tdata_i = 8'h55;
    step(); step();
    n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL fill_no_overflow got=%0d exp=4", count_o); end
    n_cmp++; if (tdata_o !== 8'h11) begin n_err++; $display("FAIL fill_head_stable got=%h exp=11", tdata_o); end
  endtask

  task automatic test_drain_from_full();
    logic [7:0] exp_out [11];
    logic [7:0] exp_out_init [11] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h56,
                                      8'h57, 8'h58, 8'h59, 8'h5A, 8'h5B};
    logic [7:0] d;
    exp_out = exp_out_init;
    d = 8'h55;
    tready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tvalid_i = 1'b1; tdata_i = d;
      #1;
      n_cmp++; if (tvalid_o !== 1'b1) begin n_err++; $display("FAIL drain_tvalid k=%0d got=%b exp=1", k, tvalid_o); end
      n_cmp++; if (tdata_o !== exp_out[k]) begin n_err++; $display("FAIL drain_data k=%0d got=%h exp=%h", k, tdata_o, exp_out[k]); end
      n_cmp++; if (tready_o !== (k != 0)) begin n_err++; $display("FAIL drain_tready k=%0d got=%b exp=%b", k, tready_o, k != 0); end
      step();
      if (k != 0) d = d + 8'h01;
      n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL drain_count k=%0d got=%0d exp=3", k, count_o); end
    end
    tvalid_i = 1'b0;
    for (int k = 8; k < 11; k++) begin
      #1;
      n_cmp++; if (tdata_o !== exp_out[k]) begin n_err++; $display("FAIL drain_tail k=%0d got=%h exp=%h", k, tdata_o, exp_out[k]); end
      step();
    end
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty_tvalid got=%b exp=0", tvalid_o); end
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL drain_empty_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_back_to_back();
    tready_i = 1'b1;
    tvalid_i = 1'b1; tdata_i = 8'h80; tlast_i = 1'b0;
    #1;
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL stream_no_bypass got=%b exp=0", tvalid_o); end
    step();
    for (int i = 1; i <= 20; i++) begin
      if (i < 20) begin
        tvalid_i = 1'b1; tdata_i = 8'(8'h80 + i); tlast_i = ((i % 5) == 4);
      end else begin
        tvalid_i = 1'b0;
      end
      #1;
      n_cmp++; if (tdata_o !== 8'(8'h80 + i - 1)) begin n_err++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, tdata_o, 8'(8'h80 + i - 1)); end
      n_cmp++; if (tlast_o !== (((i - 1) % 5) == 4)) begin n_err++; $display("FAIL stream_tlast i=%0d got=%b exp=%b", i, tlast_o, ((i - 1) % 5) == 4); end
      n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count_o); end
      step();
    end
    tlast_i = 1'b0;
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL stream_final_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush();
    tready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tvalid_i = 1'b1; tdata_i = 8'(8'h31 + i);
      step();
    end
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
    flush_i = 1'b1; tvalid_i = 1'b1; tdata_i = 8'hEE; tready_i = 1'b1;
    #1;
    n_cmp++; if (tready_o !== 1'b0) begin n_err++; $display("FAIL flush_tready got=%b exp=0", tready_o); end
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL flush_tvalid got=%b exp=0", tvalid_o); end
    step();
    flush_i = 1'b0; tvalid_i = 1'b0; tready_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL flush_post_tvalid got=%b exp=0", tvalid_o); end
    tvalid_i = 1'b1; tdata_i = 8'hA5;
    step();
    tvalid_i = 1'b0;
    n_cmp++; if (tdata_o !== 8'hA5) begin n_err++; $display("FAIL flush_first_out got=%h exp=a5", tdata_o); end
    n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL flush_after_count got=%0d exp=1", count_o); end
    tready_i = 1'b1;
    step();
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_drain_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_reset_mid();
    tready_i = 1'b0;
    tvalid_i = 1'b1; tdata_i = 8'h61; tlast_i = 1'b0; step();
    tvalid_i = 1'b1; tdata_i = 8'h62; tlast_i = 1'b1; step();
    tvalid_i = 1'b0; tlast_i = 1'b0;
    n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL rstmid_pre_count got=%0d exp=2", count_o); end
    arstn_i = 1'b0;
    step();
    arstn_i = 1'b1;
    #1;
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got=%b exp=0", tvalid_o); end
    n_cmp++; if (tready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_tready got=%b exp=1", tready_o); end
    n_cmp++; if (tdata_o !== 8'h00) begin n_err++; $display("FAIL rstmid_tdata got=%h exp=00", tdata_o); end
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rstmid_count got=%0d exp=0", count_o); end
    tvalid_i = 1'b1; tdata_i = 8'h5A;
    step();
    tvalid_i = 1'b0; tready_i = 1'b1;
    #1;
    n_cmp++; if (tdata_o !== 8'h5A) begin n_err++; $display("FAIL rstmid_beat got=%h exp=5a", tdata_o); end
    n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL rstmid_beat_count got=%0d exp=1", count_o); end
    step();
    n_cmp++; if (tvalid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_alone got=%b exp=0", tvalid_o); end
    n_cmp++; if (tdata_o !== 8'h00 || tlast_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stale got=%h/%b exp=00/0", tdata_o, tlast_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain_from_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_reg_fifo.md
# axis_reg_fifo

Parametrised AXI-Stream register buffer with configurable data width and storage depth. It carries `tlast` alongside the data and adds a synchronous flush and an occupancy output. It sits between any two AXI-Stream stages to break the combinational `tready` path and absorb bursts of up to DEPTH beats. It is the generalised successor of the team's fixed 4-bit, 2-entry stream buffer.

## Interface
- `DATA_W`, 8: payload width in bits, ≥1.
- `DEPTH`, 4: number of storage entries, power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`: derived localparam, width of `count_o`.

- `clk_i`  in  1  sole clock, rising edge.
- `arstn_i`  in  1  reset, synchronous, active-low.
- `tvalid_i`  in  1  upstream beat valid.
- `tready_o`  out  1  buffer can accept a beat.
- `tdata_i`  in  DATA_W  upstream payload.
- `tlast_i`  in  1  upstream end-of-packet marker.
- `tvalid_o`  out  1  downstream beat valid.
- `tready_i`  in  1  downstream can accept.
- `tdata_o`  out  DATA_W  downstream payload.
- `tlast_o`  out  1  downstream end-of-packet marker.
- `flush_i`  in  1  synchronous discard of all stored beats.
- `count_o`  out  CNT_W  current number of stored beats.

## Operation
- Storage: circular array of DEPTH entries of {tlast, tdata}, write pointer `wr_ptr`, read pointer `rd_ptr` (each log2(DEPTH) bits, natural wrap DEPTH-1→0), and occupancy `count` (CNT_W bits).
- Occupancy state, derived from `count`: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- `tready_o = (count != DEPTH) && !flush_i`. `tvalid_o = (count != 0) && !flush_i`.
- `tdata_o`/`tlast_o` = entry at `rd_ptr`. They are driven from registers only, with no path from `tdata_i`.
- Push = `tvalid_i && tready_o`: write the entry at `wr_ptr`, then `wr_ptr+1`.
- Pop = `tvalid_o && tready_i`: `rd_ptr+1`.
- `count` update: push only +1, pop only −1, both or neither unchanged.
- Push and pop in the same cycle are legal in PARTIAL, giving full throughput. In FULL only a pop occurs, because `tready_o` is low. In EMPTY only a push occurs.
- Transitions: EMPTY→PARTIAL on push. PARTIAL→EMPTY on pop-only with count 1. PARTIAL→FULL on push-only with count DEPTH-1. FULL→PARTIAL on pop. Otherwise the state holds.
- `flush_i` high:
  - Next edge sets `count`=0, `wr_ptr`=`rd_ptr`=0.
  - Both handshakes are suppressed in that cycle, so no beat is accepted or delivered.
  - Storage contents are not cleared.
- Priority at a clock edge: reset > flush > push/pop.
- `tlast` is stored and forwarded unmodified. The block does no packet accounting.
- `tdata_i` and `tlast_i` are sampled only on push. Their values when there is no push are don't-care.

## Timing
- Reset (arstn_i low at an edge): all pointers, `count` and storage entries go to 0. Outputs after that edge: `tready_o`=1 (unless `flush_i`), `tvalid_o`=0, `tdata_o`=0, `tlast_o`=0, `count_o`=0.
- Reset applied mid-operation discards all stored beats at that edge. Values from before reset never reappear.
- Latency: a beat pushed at edge N appears on `tdata_o` with `tvalid_o`=1 after edge N, if the buffer was empty. There is no zero-cycle bypass.
- `tready_o` and `tvalid_o` depend combinationally only on registered state and `flush_i`, never on `tready_i` or `tvalid_i`.
- `tvalid_o`, once high, stays high with stable `tdata_o`/`tlast_o` until a pop, except on flush or reset.
- `count_o` is registered and reflects the state after the most recent edge.

## Structure
- Shared package `axis_buf_pkg`:
  - occupancy state encodings EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10;
  - a `clog2`-style width helper for CNT_W and pointer width.
- One sub-module is natural: `axis_buf_mem`, a DEPTH×(DATA_W+1) register array with synchronous write, asynchronous read and synchronous reset. Pointers, count and handshake logic live in `axis_reg_fifo`.
- No other hierarchy.

## Test plan
- Reset then idle (DATA_W=8, DEPTH=4) -> `tready_o`=1, `tvalid_o`=0, `tdata_o`=0x00, `count_o`=0.
- Push 0x11, 0x22, 0x33, 0x44 with `tready_i`=0 -> `count_o` 1,2,3,4; `tready_o`=0 after 4th edge. A 5th beat 0x55 held on the input is not accepted.
- From full, `tready_i`=1 with `tvalid_i` continuously 1 and incrementing data -> output order 0x11,0x22,0x33,0x44, then 0x55 onward. One beat per cycle after the first pop. `count_o` never exceeds 4.
- Streaming with both sides always ready, pointers wrapping ≥3 times over 20 beats with `tlast_i`=1 on every 5th -> data and `tlast_o` delivered in order with 1-cycle latency. `count_o` stays 1.
- `flush_i` pulsed for one cycle while `count_o`=3 and `tvalid_i`=1 -> `tready_o`=`tvalid_o`=0 in that cycle; `count_o`=0 next cycle. The next pushed beat 0xA5 is the first beat out.
- `arstn_i` low for one edge while `count_o`=2 -> outputs return to reset values. The subsequent beat 0x5A is delivered alone.
